// File: rtl/pc_gen.sv
// pc_gen: program-counter generator feeding the fetch stage.
// Sequences reset vector, sequential advance, branch redirect with a
// one-cycle flush bubble, trap vectoring, halt and stall.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned branch targets are
// vectored to TRAP_VECTOR and flagged on misalign_err. Without it the
// target's low bits are cleared and misalign_err is tied low.
module pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          IMEM_DEPTH   = 1024,
   parameter int          IDX_W        = $clog2(IMEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boot_en,
   input  logic             stall,
   input  logic             pc_ready,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             trap,
   input  logic             halt_req,
   output logic [31:0]      pc,
   output logic [IDX_W-1:0] pc_idx,
   output logic             pc_valid,
   output logic [15:0]      redirect_cnt,
   output logic             misalign_err
);

   typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic        cnt_inc;
   logic [31:0] target_aligned;
`ifdef PC_ALIGN_CHECK_EN
   logic        mis_nxt;
`endif

   // Sequential advance wraps modulo 2^32.
   function automatic logic [31:0] pc_incr(input logic [31:0] cur);
      return cur + 32'd4;
   endfunction

   // Redirect counter sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign target_aligned = branch_target & ~32'h0000_0003;

   // Next-state, next-pc and redirect-count decisions per state.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_inc   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_nxt   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (boot_en) state_nxt = RUN;
         end
         RUN: begin
            if (trap) begin
               pc_nxt    = TRAP_VECTOR;
               state_nxt = BUBBLE;
               cnt_inc   = 1'b1;
            end else if (branch_taken) begin
`ifdef PC_ALIGN_CHECK_EN
               if (branch_target[1:0] != 2'b00) begin
                  pc_nxt  = TRAP_VECTOR;
                  mis_nxt = 1'b1;
               end else begin
                  pc_nxt  = target_aligned;
               end
`else
               pc_nxt    = target_aligned;
`endif
               state_nxt = BUBBLE;
               cnt_inc   = 1'b1;
            end else if (halt_req) begin
               state_nxt = HALT;
            end else if (pc_ready && !stall) begin
               pc_nxt    = pc_incr(pc);
            end
         end
         BUBBLE: begin
            // A branch here is ignored; only trap or halt alter the exit.
            if (trap) begin
               pc_nxt    = TRAP_VECTOR;
               cnt_inc   = 1'b1;
            end else if (halt_req) begin
               state_nxt = HALT;
            end else begin
               state_nxt = RUN;
            end
         end
         HALT: begin
            if (trap) begin
               pc_nxt    = TRAP_VECTOR;
               state_nxt = BUBBLE;
               cnt_inc   = 1'b1;
            end else if (boot_en) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, pc and valid registers; valid is high exactly while in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= RESET_VECTOR;
         pc_valid     <= 1'b0;
         redirect_cnt <= 16'h0000;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         pc_valid     <= (state_nxt == RUN);
         if (cnt_inc) redirect_cnt <= sat_inc(redirect_cnt);
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // Misalignment flag lines up with the bubble cycle it caused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else     misalign_err <= mis_nxt;
   end
`else
   assign misalign_err = 1'b0;
`endif

   assign pc_idx = pc[IDX_W+1:2];

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: boot, stall, branch, trap, halt,
// bubble events, wrap-around, misaligned branch and mid-bubble reset.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot_en, stall, pc_ready, branch_taken, trap, halt_req;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [9:0]  pc_idx;
   logic        pc_valid;
   logic [15:0] redirect_cnt;
   logic        misalign_err;

   int n_checks = 0;
   int n_fail   = 0;

   pc_gen dut (
      .clk(clk), .rst(rst), .boot_en(boot_en), .stall(stall),
      .pc_ready(pc_ready), .branch_taken(branch_taken),
      .branch_target(branch_target), .trap(trap), .halt_req(halt_req),
      .pc(pc), .pc_idx(pc_idx), .pc_valid(pc_valid),
      .redirect_cnt(redirect_cnt), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; boot_en = 0; stall = 0; pc_ready = 0;
      branch_taken = 0; branch_target = 32'h0; trap = 0; halt_req = 0;
      tick(); tick();
      n_checks++;
      if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect_cnt !== 16'h0 || misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: pc=%h valid=%b cnt=%0d mis=%b, want pc=0 valid=0 cnt=0 mis=0",
                  pc, pc_valid, redirect_cnt, misalign_err);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (pc_valid !== 1'b0 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_hold: pc=%h valid=%b, want pc=0 valid=0", pc, pc_valid);
      end
   endtask

   task automatic test_boot_seq();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
      boot_en = 1; pc_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         boot_en = 0;
         n_checks++;
         if (pc !== exp_pc[i] || pc_idx !== 10'(i) || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_seq[%0d]: pc=%h idx=%0d valid=%b, want pc=%h idx=%0d valid=1",
                     i, pc, pc_idx, pc_valid, exp_pc[i], i);
         end
      end
   endtask

   task automatic test_stall();
      tick(); tick();   // 0xC, 0x10
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc !== 32'h10 || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: pc=%h valid=%b, want pc=00000010 valid=1", i, pc, pc_valid);
         end
      end
      stall = 0;
      tick();
      n_checks++;
      if (pc !== 32'h14 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: pc=%h valid=%b, want pc=00000014 valid=1", pc, pc_valid);
      end
   endtask

   task automatic test_branch();
      tick(); tick(); tick();   // 0x18, 0x1C, 0x20
      n_checks++;
      if (pc !== 32'h20) begin
         n_fail++;
         $display("FAIL branch_pre: pc=%h, want 00000020", pc);
      end
      branch_taken = 1; branch_target = 32'h80;
      tick();
      branch_taken = 0; pc_ready = 0;
      n_checks++;
      if (pc_valid !== 1'b0 || redirect_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL branch_bubble: valid=%b cnt=%0d, want valid=0 cnt=1", pc_valid, redirect_cnt);
      end
      tick();
      n_checks++;
      if (pc !== 32'h80 || pc_valid !== 1'b1 || redirect_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL branch_target: pc=%h valid=%b cnt=%0d, want pc=00000080 valid=1 cnt=1",
                  pc, pc_valid, redirect_cnt);
      end
   endtask

   task automatic test_trap_branch();
      trap = 1; branch_taken = 1; branch_target = 32'h200;
      tick();
      trap = 0; branch_taken = 0;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b0 || redirect_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL trap_branch_bubble: pc=%h valid=%b cnt=%0d, want pc=00000100 valid=0 cnt=2",
                  pc, pc_valid, redirect_cnt);
      end
      tick();
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_branch_run: pc=%h valid=%b, want pc=00000100 valid=1", pc, pc_valid);
      end
   endtask

   task automatic test_halt();
      halt_req = 1; pc_ready = 1;
      tick();
      halt_req = 0; pc_ready = 0;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_enter: pc=%h valid=%b, want pc=00000100 valid=0", pc, pc_valid);
      end
      tick();
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_hold: pc=%h valid=%b, want pc=00000100 valid=0", pc, pc_valid);
      end
      boot_en = 1;
      tick();
      boot_en = 0;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_resume: pc=%h valid=%b, want pc=00000100 valid=1", pc, pc_valid);
      end
   endtask

   task automatic test_bubble_events();
      branch_taken = 1; branch_target = 32'h40;
      tick();
      branch_taken = 0; trap = 1;
      n_checks++;
      if (pc !== 32'h40 || pc_valid !== 1'b0 || redirect_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL bubble_branch: pc=%h valid=%b cnt=%0d, want pc=00000040 valid=0 cnt=3",
                  pc, pc_valid, redirect_cnt);
      end
      tick();
      trap = 0; halt_req = 1;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b0 || redirect_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL bubble_trap: pc=%h valid=%b cnt=%0d, want pc=00000100 valid=0 cnt=4",
                  pc, pc_valid, redirect_cnt);
      end
      tick();
      halt_req = 0;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bubble_halt: pc=%h valid=%b, want pc=00000100 valid=0", pc, pc_valid);
      end
      tick();
      n_checks++;
      if (pc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bubble_halt_hold: valid=%b, want 0", pc_valid);
      end
      boot_en = 1;
      tick();
      boot_en = 0;
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bubble_resume: pc=%h valid=%b, want pc=00000100 valid=1", pc, pc_valid);
      end
   endtask

   task automatic test_wrap();
      branch_taken = 1; branch_target = 32'hFFC;
      tick();
      branch_taken = 0;
      tick();
      n_checks++;
      if (pc !== 32'hFFC || pc_idx !== 10'd1023 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL idx_top: pc=%h idx=%0d valid=%b, want pc=00000ffc idx=1023 valid=1",
                  pc, pc_idx, pc_valid);
      end
      pc_ready = 1;
      tick();
      pc_ready = 0;
      n_checks++;
      if (pc !== 32'h1000 || pc_idx !== 10'd0) begin
         n_fail++;
         $display("FAIL idx_wrap: pc=%h idx=%0d, want pc=00001000 idx=0", pc, pc_idx);
      end
      branch_taken = 1; branch_target = 32'hFFFF_FFFC;
      tick();
      branch_taken = 0;
      tick();
      pc_ready = 1;
      tick();
      pc_ready = 0;
      n_checks++;
      if (pc !== 32'h0 || pc_idx !== 10'd0 || pc_valid !== 1'b1 || redirect_cnt !== 16'd6) begin
         n_fail++;
         $display("FAIL pc_wrap: pc=%h idx=%0d valid=%b cnt=%0d, want pc=0 idx=0 valid=1 cnt=6",
                  pc, pc_idx, pc_valid, redirect_cnt);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] exp_pc;
      logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
      exp_pc = 32'h100; exp_mis = 1'b1;
`else
      exp_pc = 32'h40;  exp_mis = 1'b0;
`endif
      branch_taken = 1; branch_target = 32'h43;
      tick();
      branch_taken = 0;
      n_checks++;
      if (pc !== exp_pc || misalign_err !== exp_mis || pc_valid !== 1'b0 || redirect_cnt !== 16'd7) begin
         n_fail++;
         $display("FAIL misalign_bubble: pc=%h mis=%b valid=%b cnt=%0d, want pc=%h mis=%b valid=0 cnt=7",
                  pc, misalign_err, pc_valid, redirect_cnt, exp_pc, exp_mis);
      end
      tick();
      n_checks++;
      if (pc !== exp_pc || misalign_err !== 1'b0 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_after: pc=%h mis=%b valid=%b, want pc=%h mis=0 valid=1",
                  pc, misalign_err, pc_valid, exp_pc);
      end
   endtask

   task automatic test_reset_mid_bubble();
      branch_taken = 1; branch_target = 32'h80;
      tick();
      branch_taken = 0;
      n_checks++;
      if (pc !== 32'h80 || pc_valid !== 1'b0 || redirect_cnt !== 16'd8) begin
         n_fail++;
         $display("FAIL pre_reset_bubble: pc=%h valid=%b cnt=%0d, want pc=00000080 valid=0 cnt=8",
                  pc, pc_valid, redirect_cnt);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL async_reset: pc=%h valid=%b cnt=%0d, want pc=0 valid=0 cnt=0",
                  pc, pc_valid, redirect_cnt);
      end
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (pc_valid !== 1'b0 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL post_reset_idle: pc=%h valid=%b, want pc=0 valid=0", pc, pc_valid);
      end
   endtask

   initial begin
      test_reset();
      test_boot_seq();
      test_stall();
      test_branch();
      test_trap_branch();
      test_halt();
      test_bubble_events();
      test_wrap();
      test_misalign();
      test_reset_mid_bubble();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generator that drives the fetch stage's instruction-memory index, one word address per accepted request.
- Sits directly upstream of fetch.
- Owns sequencing: reset vector, sequential advance, branch redirect with one-cycle bubble, trap vectoring, halt and stall.
- Fetch consumes pc_idx/pc_valid; execute/control logic drives branch, trap and halt inputs.

Parameters:
- RESET_VECTOR, 32'h0000_0000: byte address loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: byte address loaded on trap.
- IMEM_DEPTH, 1024: instruction-memory words; must be a power of two, at least 2.
- IDX_W, $clog2(IMEM_DEPTH): width of the word index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- boot_en  in  1  start/resume request; level, sampled in IDLE/HALT
- stall  in  1  hold current PC (pipeline backpressure)
- pc_ready  in  1  fetch accepts current PC this cycle
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  32  redirect byte address
- trap  in  1  exception redirect, single-cycle pulse
- halt_req  in  1  stop issuing PCs
- pc  out  32  current byte address
- pc_idx  out  IDX_W  word index pc[IDX_W+1:2] into instruction memory
- pc_valid  out  1  pc is a valid fetch request
- redirect_cnt  out  16  saturating count of branch+trap redirects
- misalign_err  out  1  one-cycle pulse; only present with PC_ALIGN_CHECK_EN (else tied 0)

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VECTOR, pc_valid=0, redirect_cnt=0, misalign_err=0.
  - state=IDLE.
- States: IDLE, RUN, BUBBLE, HALT. All outputs registered.
- IDLE:
  - pc_valid=0, pc held.
  - boot_en=1 -> RUN next cycle; pc_valid=1 from that cycle.
- RUN, priority per cycle (highest first):
  1. trap: pc<=TRAP_VECTOR, pc_valid<=0, go BUBBLE, redirect_cnt++.
  2. branch_taken: pc<=branch_target with bits[1:0] forced 0, pc_valid<=0, go BUBBLE, redirect_cnt++.
  3. halt_req: pc held, pc_valid<=0, go HALT. The current PC is not consumed even if pc_ready=1.
  4. stall=1 or pc_ready=0: hold pc and pc_valid=1.
  5. pc_ready=1 and stall=0: pc<=pc+4.
- Handshake: a PC is consumed only on a cycle with pc_valid & pc_ready & !stall and no trap/branch/halt. pc must not change while pc_valid=1 and it is unconsumed.
- BUBBLE:
  - Exactly one cycle with pc_valid=0; gives fetch a flush slot.
  - Then RUN with pc_valid=1 at the new pc.
  - trap in BUBBLE: re-vectors to TRAP_VECTOR, stays BUBBLE one more cycle, counts.
  - branch_taken in BUBBLE: ignored; upstream must not issue it.
  - halt_req in BUBBLE: go HALT instead of RUN.
- HALT:
  - pc_valid=0, pc held.
  - boot_en=1 -> RUN resuming at held pc.
  - trap in HALT: pc<=TRAP_VECTOR, go BUBBLE.
- Arithmetic and wrap-around:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
  - pc_idx wraps modulo IMEM_DEPTH as plain bit-slicing; no range error raised.
  - redirect_cnt saturates at 16'hFFFF.
- Simultaneous events: trap+branch -> trap wins, redirect_cnt increments by 1 only. trap+halt -> trap wins; halt_req must be re-asserted.
- Reset mid-operation: immediate return to reset values regardless of state; counter cleared.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: a taken branch with branch_target[1:0]!=0 is treated as a trap:
  - pc<=TRAP_VECTOR, go BUBBLE.
  - misalign_err pulses 1 for one cycle, registered, coincident with the BUBBLE cycle.
  - redirect_cnt increments once.
- Not defined: target low bits silently cleared and the branch proceeds normally; misalign_err tied 0.

Test Plan:
- Reset, then boot_en=1, pc_ready=1 held -> pc_valid rises cycle after boot. pc sequence 0x0, 0x4, 0x8; pc_idx 0, 1, 2.
- In RUN at pc=0x10, stall=1 for 3 cycles -> pc stays 0x10, pc_valid=1. Stall release -> 0x14.
- At pc=0x20, branch_taken with target 0x80 -> one cycle pc_valid=0, then pc=0x80 valid, redirect_cnt=1.
- trap and branch_taken same cycle -> pc=0x100 after bubble, redirect_cnt increments by 1. Separately, halt_req then boot_en resumes at the held pc.
- Force pc near end: pc=0xFFC with IMEM_DEPTH=1024, consume -> pc=0x1000, pc_idx=0. Wrap check: pc 0xFFFF_FFFC -> 0x0.
- Branch to 0x43:
  - With PC_ALIGN_CHECK_EN: misalign_err pulses, pc=0x100.
  - Without it: pc=0x40.
  - rst asserted mid-bubble: pc=0x0, pc_valid=0 immediately.
